// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pattern scheduler.
//   pattern_t : test pattern index
//   rgb3_t    : {r,g,b} colour
//   regs_t    : one full set of shadow/active configuration registers
//   CFG_*     : config register addresses
//   REGS_RST  : reset defaults (auto mode, border 21, edge 111, fill 001, 60 fpp)
package vga_pkg;

  typedef enum logic [1:0] {PAT_BORDER, PAT_BARS, PAT_CHECK, PAT_SOLID} pattern_t;
  typedef enum logic {ST_RUN, ST_COMMIT} state_t;
  typedef logic [2:0] rgb3_t;

  localparam logic [1:0] CFG_MODE   = 2'd0;
  localparam logic [1:0] CFG_BORDER = 2'd1;
  localparam logic [1:0] CFG_COLOR  = 2'd2;
  localparam logic [1:0] CFG_FPP    = 2'd3;

  localparam logic [2:0]  RST_MODE   = 3'b001;
  localparam logic [7:0]  RST_BORDER = 8'd21;
  localparam rgb3_t       RST_EDGE   = 3'b111;
  localparam rgb3_t       RST_FILL   = 3'b001;
  localparam logic [15:0] RST_FPP    = 16'd60;

  // mode[0] = auto rotate, mode[2:1] = manual pattern
  typedef struct packed {
    logic [2:0]  mode;
    logic [7:0]  border;
    rgb3_t       fill_col;
    rgb3_t       edge_col;
    logic [15:0] fpp;
  } regs_t;

  localparam regs_t REGS_RST = '{mode: RST_MODE, border: RST_BORDER,
                                 fill_col: RST_FILL, edge_col: RST_EDGE,
                                 fpp: RST_FPP};

  // A frames-per-pattern of zero behaves as one.
  function automatic logic [15:0] fpp_eff(input logic [15:0] f);
    return (f == 16'd0) ? 16'd1 : f;
  endfunction

endpackage

// File: rtl/pattern_scheduler_if.sv
// Config write port: valid/ready handshake carrying a register address and data.
//   master drives cfg_valid/cfg_addr/cfg_data, slave drives cfg_ready.
interface pattern_scheduler_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_data;

  modport master (output cfg_valid, cfg_addr, cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, cfg_addr, cfg_data, output cfg_ready);
endinterface

// File: rtl/pixel_painter.sv
// Per-pixel colour generator. Produces registered r/g/b one cycle after the
// x/y/disp_enable inputs, using the active pattern and colour registers.
//   clk, rst_n            : pixel clock, async active-low reset
//   disp_enable, x, y     : timing-generator pixel position
//   pat, border           : active pattern and border width
//   edge_col, fill_col    : active colours
//   r, g, b               : registered colour, 0 outside the display area
module pixel_painter
  import vga_pkg::*;
#(
  parameter int H_DISP = 640,
  parameter int V_DISP = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_enable,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  pattern_t    pat,
  input  logic [7:0]  border,
  input  rgb3_t       edge_col,
  input  rgb3_t       fill_col,
  output logic        r,
  output logic        g,
  output logic        b
);
  localparam logic [31:0] H_LAST = 32'(H_DISP - 1);
  localparam logic [31:0] V_LAST = 32'(V_DISP - 1);
  localparam logic [31:0] BAR_W  = 32'(H_DISP / 8);

  logic [31:0] w;
  logic        in_border;
  rgb3_t       colour;

  assign w = {24'd0, border};

  always_comb begin
    // Width 0 disables the border entirely, including off-screen coordinates.
    in_border = (w != 32'd0) &&
                ((x < w) || (x > H_LAST - w) || (y < w) || (y > V_LAST - w));
    colour = fill_col;
    unique case (pat)
      PAT_BORDER: if (in_border) colour = edge_col;
      PAT_BARS:   colour = 3'(x / BAR_W);
      PAT_CHECK:  if (x[5] ^ y[5]) colour = edge_col;
      PAT_SOLID:  colour = fill_col;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {r, g, b} <= 3'b000;
    else        {r, g, b} <= disp_enable ? colour : 3'b000;
  end
endmodule

// File: rtl/pattern_scheduler.sv
// Frame-synchronous test pattern scheduler for the VGA colour stage.
// Config writes land in shadow registers; on each vsync falling edge a
// one-cycle COMMIT copies all shadows to the active set and advances the
// pattern, so every frame is drawn with one consistent configuration.
//   clk, rst_n          : pixel clock, async active-low reset
//   vsync               : active-low vertical sync
//   disp_enable, X, Y   : active-area flag and pixel position
//   cfg                 : config write port (slave)
//   pat_sel             : active pattern index
//   frame_start         : one-cycle pulse during COMMIT
//   r, g, b             : registered pixel colour
module pattern_scheduler
  import vga_pkg::*;
#(
  parameter int H_DISP       = 640,
  parameter int V_DISP       = 480,
  parameter int NUM_PATTERNS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vsync,
  input  logic                disp_enable,
  input  logic [31:0]         X,
  input  logic [31:0]         Y,
  pattern_scheduler_if.slave  cfg,
  output logic [1:0]          pat_sel,
  output logic                frame_start,
  output logic                r,
  output logic                g,
  output logic                b
);
  state_t      state;
  regs_t       shadow, active;
  pattern_t    pat;
  logic        vsync_q, ready_q, fall;
  logic [15:0] frame_cnt;
  logic [16:0] cnt_inc;

  // vsync_q resets low so a vsync already low at reset release is not a boundary.
  assign fall          = vsync_q & ~vsync;
  assign cnt_inc       = {1'b0, frame_cnt} + 17'd1;
  assign cfg.cfg_ready = ready_q;
  assign pat_sel       = pat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      vsync_q     <= 1'b0;
      ready_q     <= 1'b0;
      frame_start <= 1'b0;
      shadow      <= REGS_RST;
      active      <= REGS_RST;
      frame_cnt   <= '0;
      pat         <= PAT_BORDER;
    end else begin
      vsync_q <= vsync;

      if (cfg.cfg_valid && ready_q) begin
        unique case (cfg.cfg_addr)
          CFG_MODE:   shadow.mode <= cfg.cfg_data[2:0];
          CFG_BORDER: shadow.border <= cfg.cfg_data[7:0];
          CFG_COLOR:  {shadow.fill_col, shadow.edge_col} <= cfg.cfg_data[5:0];
          CFG_FPP:    shadow.fpp <= cfg.cfg_data;
        endcase
      end

      unique case (state)
        ST_RUN: begin
          state       <= fall ? ST_COMMIT : ST_RUN;
          frame_start <= fall;
          ready_q     <= ~fall;
        end
        ST_COMMIT: begin
          // cfg_ready is low here, so shadow is stable while it is copied.
          state       <= ST_RUN;
          frame_start <= 1'b0;
          ready_q     <= 1'b1;
          active      <= shadow;
          if (shadow.mode[0]) begin
            // >= rather than == so a shrinking FPP cannot strand the counter.
            if (cnt_inc >= {1'b0, fpp_eff(shadow.fpp)}) begin
              frame_cnt <= '0;
              pat       <= (pat == pattern_t'(NUM_PATTERNS - 1)) ? PAT_BORDER
                                                                 : pattern_t'(pat + 2'd1);
            end else begin
              frame_cnt <= cnt_inc[15:0];
            end
          end else begin
            pat       <= pattern_t'(shadow.mode[2:1]);
            frame_cnt <= '0;
          end
        end
      endcase
    end
  end

  pixel_painter #(.H_DISP(H_DISP), .V_DISP(V_DISP)) u_painter (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp_enable (disp_enable),
    .x           (X),
    .y           (Y),
    .pat         (pat),
    .border      (active.border),
    .edge_col    (active.edge_col),
    .fill_col    (active.fill_col),
    .r           (r),
    .g           (g),
    .b           (b)
  );
endmodule

// File: tb/tb_pattern_scheduler.sv
// Scoreboard bench for pattern_scheduler: stimulus steps a frame-level model
// and queues the expected outputs; a negedge monitor compares them.
module tb_pattern_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b1;
  logic        disp_enable = 1'b0;
  logic [31:0] X = '0, Y = '0;
  logic [1:0]  pat_sel;
  logic        frame_start, r, g, b;

  pattern_scheduler_if cfg_if();

  pattern_scheduler dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .disp_enable(disp_enable),
    .X(X), .Y(Y), .cfg(cfg_if), .pat_sel(pat_sel),
    .frame_start(frame_start), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] rgb;
    logic [1:0] pat;
    logic       fs;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: register sets, frame count, current pattern.
  int sh_mode, sh_border, sh_color, sh_fpp;
  int ac_mode, ac_border, ac_color, ac_fpp;
  int cnt, pat;
  bit vs_prev, in_commit, m_rdy;

  function automatic void model_reset();
    sh_mode = 1; sh_border = 21; sh_color = (1 << 3) | 7; sh_fpp = 60;
    ac_mode = sh_mode; ac_border = sh_border; ac_color = sh_color; ac_fpp = sh_fpp;
    cnt = 0; pat = 0; vs_prev = 0; in_commit = 0; m_rdy = 0;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
    end
  endfunction

  function automatic logic [2:0] paint(bit de, longint x, longint y);
    longint w;
    logic [2:0] ec, fc;
    w  = ac_border;
    ec = 3'(ac_color & 7);
    fc = 3'((ac_color >> 3) & 7);
    if (!de) return 3'b000;
    case (pat)
      0: return (w > 0 && (x < w || x >= 640 - w || y < w || y >= 480 - w)) ? ec : fc;
      1: return 3'((x / 80) % 8);
      2: return (((x / 32) % 2) != ((y / 32) % 2)) ? ec : fc;
      default: return fc;
    endcase
  endfunction

  // One pixel-clock cycle of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic step(input bit vs, input bit de, input int x, input int y,
                      input bit v, input int a, input int d, output bit acc);
    exp_t e;
    int   f;
    vsync = vs; disp_enable = de; X = 32'(x); Y = 32'(y);
    cfg_if.cfg_valid = v; cfg_if.cfg_addr = 2'(a); cfg_if.cfg_data = 16'(d);
    e.cyc = cyc + 1;
    e.rgb = paint(de, x, y);
    acc = v && m_rdy;
    if (acc) begin
      case (a)
        0: sh_mode   = d & 7;
        1: sh_border = d & 255;
        2: sh_color  = d & 63;
        default: sh_fpp = d & 65535;
      endcase
    end
    if (in_commit) begin
      ac_mode = sh_mode; ac_border = sh_border; ac_color = sh_color; ac_fpp = sh_fpp;
      if (ac_mode & 1) begin
        f = (ac_fpp == 0) ? 1 : ac_fpp;
        cnt++;
        if (cnt >= f) begin cnt = 0; pat = (pat + 1) % 4; end
      end else begin
        pat = (ac_mode >> 1) & 3;
        cnt = 0;
      end
    end
    in_commit = vs_prev && !vs;
    vs_prev   = vs;
    m_rdy     = !in_commit;
    e.pat = 2'(pat); e.fs = in_commit; e.rdy = m_rdy;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic pix();
    bit acc;
    step(1, $urandom_range(0, 9) != 0, $urandom_range(0, 699), $urandom_range(0, 499), 0, 0, 0, acc);
  endtask

  task automatic px(input int x, input int y);
    bit acc;
    step(1, 1, x, y, 0, 0, 0, acc);
  endtask

  task automatic pixels(input int n);
    repeat (n) pix();
  endtask

  // Holds valid until the model says the write is taken (COMMIT blocks one cycle).
  task automatic cfg_write(input int a, input int d);
    bit acc;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, $urandom_range(0, 699), $urandom_range(0, 499), 1, a, d, acc);
      if (acc) break;
    end
  endtask

  // vsync low for n cycles; an optional config write rides on the falling cycle.
  task automatic boundary(input int n, input bit v, input int a, input int d);
    bit acc;
    step(0, 1, $urandom_range(0, 699), $urandom_range(0, 499), v, a, d, acc);
    repeat (n - 1) step(0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_rgb"}, {r, g, b}, 0);
    check({tag, "_pat_sel"}, pat_sel, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_cfg_ready"}, cfg_if.cfg_ready, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        vectors++; miscompares++;
        $display("FAIL stale_expect: got no sample expected one for cycle %0d", q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        mon_e = q.pop_front();
        check("rgb", {r, g, b}, mon_e.rgb);
        check("pat_sel", pat_sel, mon_e.pat);
        check("frame_start", frame_start, mon_e.fs);
        check("cfg_ready", cfg_if.cfg_ready, mon_e.rdy);
      end
    end
  end

  initial begin
    int a, d;
    model_reset();
    cfg_if.cfg_valid = 0; cfg_if.cfg_addr = 0; cfg_if.cfg_data = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_outputs_zero("reset");
    rst_n = 1; mon_en = 1;

    // Default frame: border pattern, width 21.
    pixels(4);
    px(0, 0); px(100, 100); px(618, 240); px(619, 240); px(620, 240); px(320, 479);
    step(1, 0, 0, 0, 0, 0, 0, d[0]);

    // Auto rotation with two frames per pattern.
    cfg_write(3, 2);
    pixels(3);
    repeat (9) begin boundary($urandom_range(1, 3), 0, 0, 0); pixels(6); end

    // Manual checkerboard written mid-frame with distinct edge/fill colours.
    cfg_write(2, 'h15);
    pixels(3);
    cfg_write(0, 4);
    pixels(4);
    boundary(1, 0, 0, 0);
    px(32, 0); px(32, 0); px(0, 0); px(32, 32); pixels(20);

    // Bars and solid.
    cfg_write(0, 2); boundary(2, 0, 0, 0); pixels(30);
    cfg_write(0, 6); boundary(2, 0, 0, 0); pixels(20);

    // Border width written on the vsync falling cycle.
    cfg_write(0, 0); boundary(1, 0, 0, 0); pixels(3);
    boundary(1, 1, 1, 5);
    px(5, 240); px(4, 240);
    px(5, 240); px(4, 240); px(635, 240); px(634, 240); px(300, 4); px(300, 475);

    // Zero width: no border anywhere.
    cfg_write(1, 0); boundary(1, 0, 0, 0); px(0, 0); px(0, 0); px(639, 479); pixels(5);

    // Write held across COMMIT: back to auto.
    boundary(1, 0, 0, 0);
    cfg_write(0, 1);
    pixels(5);

    // Random soak.
    repeat (300) begin
      case ($urandom_range(0, 19))
        0: begin
          a = $urandom_range(0, 3);
          d = (a == 3) ? $urandom_range(0, 3) : $urandom_range(0, 65535);
          boundary($urandom_range(1, 3), $urandom_range(0, 1), a, d);
        end
        1, 2, 3: begin
          a = $urandom_range(0, 3);
          d = (a == 3) ? $urandom_range(0, 3) : $urandom_range(0, 65535);
          cfg_write(a, d);
        end
        default: pix();
      endcase
    end

    // Reset pulse in COMMIT discards the pending shadow writes.
    cfg_write(0, 7); cfg_write(1, 9); cfg_write(2, 'h3f);
    pixels(3);
    boundary(1, 0, 0, 0);
    mon_en = 0;
    q.delete();
    rst_n = 0;
    #2;
    reset_outputs_zero("commit_reset");
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    mon_en = 1;
    pixels(3);
    boundary(1, 0, 0, 0); px(0, 0); px(0, 0); px(620, 240); pixels(8);
    boundary(2, 0, 0, 0); pixels(8);

    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
